frogger_hazard_ctrl: RTL

//  Upstream of the frog controller: owns the scrolling hazard lanes (cars, logs).
//  - Advances one wrap-around offset per lane on independent lane timers.
//  - Tests the frog cell against the lanes and drives the frog controller's i_Collided / i_On_Log.
//  - Serves the renderer a per-cell hazard tile code for the current scan cell.

---
 rtl/frogger_pkg.sv | 41 ++++
 rtl/frogger_hazard_ctrl_lane_timer.sv | 46 ++++
 rtl/frogger_hazard_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared playfield constants, hazard tile codes and lane pattern functions
// used by the hazard controller and the renderer.
package frogger_pkg;

   localparam int unsigned c_GAME_WIDTH  = 20;
   localparam int unsigned c_GAME_HEIGHT = 15;

   localparam logic [5:0] c_RIVER_FIRST = 6'd1;
   localparam logic [5:0] c_RIVER_LAST  = 6'd6;
   localparam logic [5:0] c_ROAD_FIRST  = 6'd8;
   localparam logic [5:0] c_ROAD_LAST   = 6'd13;

   typedef enum logic [3:0] {
      TILE_NONE  = 4'd0,
      TILE_WATER = 4'd2,
      TILE_LOG   = 4'd3,
      TILE_GOAL  = 4'd4,
      TILE_CAR   = 4'd5
   } tile_e;

   function automatic logic is_river(input logic [5:0] row);
      return (row >= c_RIVER_FIRST) && (row <= c_RIVER_LAST);
   endfunction

   function automatic logic is_road(input logic [5:0] row);
      return (row >= c_ROAD_FIRST) && (row <= c_ROAD_LAST);
   endfunction

   function automatic logic is_log(input logic [5:0] c, input logic [5:0] lane);
      int unsigned s;
      s = 32'(c) + 32'd3 * 32'(lane);
      return (s % 32'd10) < 32'd4;
   endfunction

   function automatic logic is_car(input logic [5:0] c, input logic [5:0] lane);
      int unsigned s;
      s = 32'(c) + 32'd2 * 32'(lane);
      return (s % 32'd5) == 32'd0;
   endfunction

endpackage

// File: rtl/frogger_hazard_ctrl_lane_timer.sv
// lane_timer: enabled divider emitting a one-cycle step on each wrap; the
// period is re-sampled at every wrap so the next count uses the new value.
module lane_timer
   import frogger_pkg::*;
#(
   parameter int unsigned c_PERIOD = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [31:0] period_i,
   output logic        step_o
);

   logic [31:0] cnt_q, cnt_d;
   logic [31:0] lim_q, lim_d;
   logic        wrap;

   always_comb begin
      wrap  = en_i && (cnt_q >= lim_q - 32'd1);
      cnt_d = cnt_q;
      lim_d = lim_q;
      if (en_i) begin
         if (wrap) begin
            cnt_d = '0;
            // a period shifted down to zero would never wrap; clamp to one clock
            lim_d = (period_i == '0) ? 32'd1 : period_i;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         lim_q <= 32'(c_PERIOD);
      end else begin
         cnt_q <= cnt_d;
         lim_q <= lim_d;
      end
   end

   assign step_o = wrap;

endmodule

// File: rtl/frogger_hazard_ctrl.sv
// Hazard lane controller: scrolls river/road lane offsets, tests the frog cell
// and serves hazard tiles to the renderer. Optional HAZARD_SPEEDUP_EN shortens
// lane periods as the score rises.
module frogger_hazard_ctrl
   import frogger_pkg::*;
#(
   parameter int unsigned c_RIVER_PERIOD = 39000000,
   parameter int unsigned c_ROAD_PERIOD  = 6250000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Game_En,
   input  logic [5:0] i_Frogger_X,
   input  logic [5:0] i_Frogger_Y,
   input  logic [5:0] i_Col_Count_Div,
   input  logic [5:0] i_Row_Count_Div,
   input  logic [6:0] i_Score,
   output logic       o_Collided,
   output logic       o_On_Log,
   output logic [3:0] o_Hazard_Tile,
   output logic       o_Lane_Step
);

   localparam int unsigned c_ROWS = 16;

   logic [c_ROWS-1:0] step;
   logic [4:0]        off_q [c_ROWS];
   logic [4:0]        off_d [c_ROWS];
   logic [1:0]        shift;
   logic              collided_q, collided_d;
   logic              on_log_q, on_log_d;
   logic              lane_step_q;
   tile_e             tile_q, tile_d;
   logic [5:0]        frog_cell, scan_cell;

`ifdef HAZARD_SPEEDUP_EN
   always_comb begin
      shift = 2'd0;
      if (i_Score >= 7'd20)      shift = 2'd2;
      else if (i_Score >= 7'd10) shift = 2'd1;
   end
`else
   logic unused_score;
   assign unused_score = ^i_Score;
   assign shift        = 2'd0;
`endif

   for (genvar r = 0; r < c_ROWS; r++) begin : g_lane
      if (is_river(6'(r)) || is_road(6'(r))) begin : g_timer
         localparam int unsigned c_P = is_river(6'(r)) ? c_RIVER_PERIOD
                                     : c_ROAD_PERIOD * (32'd1 + unsigned'(r) % 32'd3);
         lane_timer #(.c_PERIOD(c_P)) u_timer (
            .clk_i   (i_Clk),
            .rst_ni  (i_Rst_L),
            .en_i    (i_Game_En),
            .period_i(c_P >> shift),
            .step_o  (step[r])
         );
      end else begin : g_idle
         assign step[r] = 1'b0;
      end
   end

   // Even road lanes scroll right (x - off), everything else scrolls left.
   function automatic logic [5:0] lane_cell(input logic [5:0] x, input logic [4:0] off,
                                            input logic [5:0] row);
      logic [6:0] s;
      if (is_road(row) && !row[0]) s = 7'(x) + 7'(c_GAME_WIDTH) - 7'(off);
      else                         s = 7'(x) + 7'(off);
      return (s >= 7'(c_GAME_WIDTH)) ? 6'(s - 7'(c_GAME_WIDTH)) : s[5:0];
   endfunction

   always_comb begin
      for (int unsigned r = 0; r < c_ROWS; r++) begin
         off_d[r] = off_q[r];
         if (step[r]) off_d[r] = (off_q[r] == 5'(c_GAME_WIDTH - 1)) ? '0 : off_q[r] + 5'd1;
      end
   end

   always_comb begin
      frog_cell  = lane_cell(i_Frogger_X, off_q[i_Frogger_Y[3:0]], i_Frogger_Y);
      collided_d = (i_Frogger_X < 6'(c_GAME_WIDTH)) && is_road(i_Frogger_Y)
                   && is_car(frog_cell, i_Frogger_Y);
      on_log_d   = (i_Frogger_X < 6'(c_GAME_WIDTH)) && is_river(i_Frogger_Y)
                   && is_log(frog_cell, i_Frogger_Y);

      scan_cell  = lane_cell(i_Col_Count_Div, off_q[i_Row_Count_Div[3:0]], i_Row_Count_Div);
      tile_d     = TILE_NONE;
      if (i_Col_Count_Div < 6'(c_GAME_WIDTH)) begin
         if (is_river(i_Row_Count_Div))
            tile_d = is_log(scan_cell, i_Row_Count_Div) ? TILE_LOG : TILE_WATER;
         else if (is_road(i_Row_Count_Div) && is_car(scan_cell, i_Row_Count_Div))
            tile_d = TILE_CAR;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         for (int unsigned r = 0; r < c_ROWS; r++) off_q[r] <= '0;
         collided_q  <= 1'b0;
         on_log_q    <= 1'b0;
         tile_q      <= TILE_NONE;
         lane_step_q <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < c_ROWS; r++) off_q[r] <= off_d[r];
         collided_q  <= collided_d;
         on_log_q    <= on_log_d;
         tile_q      <= tile_d;
         lane_step_q <= |step;
      end
   end

   assign o_Collided    = collided_q;
   assign o_On_Log      = on_log_q;
   assign o_Hazard_Tile = tile_q;
   assign o_Lane_Step   = lane_step_q;

endmodule
